// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, counter type and decode helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing_pkg;

  // 640x480@60 segment defaults (pixels / lines)
  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOT_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
  localparam int V_TOT_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

  // Counter width covers both totals
  localparam int CNT_W = 10;

  // Level driven on HSync/VSync during the sync pulse
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef logic [CNT_W-1:0] cnt_t;

  // Registered per-pixel decode flags
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } vga_decode_t;

  // Inclusive window test on a counter value
  function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Clock divider: one-cycle tick once every CLK_DIV system clocks.
// Latency: tick decoded combinationally from the divider register; first tick CLK_DIV-1 clocks after reset release.
// Backpressure: none, free-running.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Wrap the divider at CLK_DIV-1
  always_comb begin
    div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
  end

  // Divider register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick_o = (div_q == DIV_MAX);

endmodule

// File: rtl/vga_frame_ctrl.sv
// VGA timing: pixel tick, H/V counters, registered sync/visible decode, frame-synchronous value shadow.
// Latency: decode flags aligned with pixel_x/pixel_y; value_disp updates only on the (0,0) wrap edge.
// Backpressure: none, free-running; value_wr is never stalled (last write in a frame wins).
module vga_frame_ctrl
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       value,
  input  logic             value_wr,
  output logic             pixel_tick,
  output logic             HSync,
  output logic             VSync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic [4:0]       value_disp,
  output logic             frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST   = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOT - 1);
  localparam cnt_t H_VIS_C  = cnt_t'(H_VIS);
  localparam cnt_t V_VIS_C  = cnt_t'(V_VIS);
  localparam cnt_t HS_FIRST = cnt_t'(H_VIS + H_FP);
  localparam cnt_t HS_LAST  = cnt_t'(H_VIS + H_FP + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_VIS + V_FP);
  localparam cnt_t VS_LAST  = cnt_t'(V_VIS + V_FP + V_SYNC - 1);

  // (0,0) is visible and outside both sync windows
  localparam vga_decode_t DEC_RST = '{hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE, video_on: 1'b1};

  logic        tick;
  logic        wrap;
  cnt_t        x_q, x_d;
  cnt_t        y_q, y_d;
  vga_decode_t dec_q, dec_d;
  logic        fs_q;
  logic [4:0]  pend_q;
  logic        pend_v_q;
  logic [4:0]  disp_q;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (tick)
  );

  // Last pixel of the last line, about to wrap to (0,0) on this edge
  assign wrap = tick && (x_q == H_LAST) && (y_q == V_LAST);

  // Next-state counters: pixel per tick, line on pixel wrap
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + cnt_t'(1);
      end else begin
        x_d = x_q + cnt_t'(1);
      end
    end
  end

  // Decode from next-state counters so the registered flags match the registered counters
  always_comb begin
    dec_d.hsync    = in_window(x_d, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    dec_d.vsync    = in_window(y_d, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    dec_d.video_on = (x_d < H_VIS_C) && (y_d < V_VIS_C);
  end

  // Counter, decode and frame-start registers; reset drops any sync pulse immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      dec_q <= DEC_RST;
      fs_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      dec_q <= dec_d;
      fs_q  <= wrap;
    end
  end

  // Value shadow: writes collect in pend, the frame wrap publishes the pre-edge pend
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      disp_q   <= '0;
    end else begin
      if (wrap && pend_v_q) begin
        disp_q   <= pend_q;
        pend_v_q <= 1'b0;
      end
      // A write on the wrap edge stays pending for the following frame
      if (value_wr) begin
        pend_q   <= value;
        pend_v_q <= 1'b1;
      end
    end
  end

  assign pixel_tick  = tick;
  assign HSync       = dec_q.hsync;
  assign VSync       = dec_q.vsync;
  assign video_on    = dec_q.video_on;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign value_disp  = disp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Directed bench for vga_frame_ctrl on a shrunken raster so whole frames fit in a short run.
// Raster: H_TOT=16 (vis 8, HSync low x=10..12), V_TOT=10 (vis 5, VSync low y=6..7), CLK_DIV=4.
// Line = 64 clks, frame = 640 clks, HSync low 12 clks/line, VSync low 128 clks/frame.
module tb_vga_frame_ctrl;

  localparam int CLK_DIV = 4;
  localparam int H_VIS = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_VIS = 5, V_FP = 1, V_SYNC = 2, V_BP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] value = 5'd0;
  logic       value_wr = 1'b0;
  logic       pixel_tick, HSync, VSync, video_on, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic [4:0] value_disp;

  int n_chk = 0;
  int n_pass = 0;

  vga_frame_ctrl #(
    .CLK_DIV (CLK_DIV),
    .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .value_wr    (value_wr),
    .pixel_tick  (pixel_tick),
    .HSync       (HSync),
    .VSync       (VSync),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .value_disp  (value_disp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Advance to a negedge where the counters match; x/y < 0 means don't care
  task automatic wait_at(input int x, input int y, input bit need_tick, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((x < 0 || int'(pixel_x) == x) && (y < 0 || int'(pixel_y) == y) && (!need_tick || pixel_tick)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1; value = 5'd21; value_wr = 1'b1;   // write during reset must be ignored
    repeat (2) @(negedge clk);
    n_chk++; if (pixel_x !== 10'd0) $display("FAIL reset_x got %0d want 0", pixel_x); else n_pass++;
    n_chk++; if (pixel_y !== 10'd0) $display("FAIL reset_y got %0d want 0", pixel_y); else n_pass++;
    n_chk++; if (HSync !== 1'b1) $display("FAIL reset_hsync got %b want 1", HSync); else n_pass++;
    n_chk++; if (VSync !== 1'b1) $display("FAIL reset_vsync got %b want 1", VSync); else n_pass++;
    n_chk++; if (video_on !== 1'b1) $display("FAIL reset_video_on got %b want 1", video_on); else n_pass++;
    n_chk++; if (value_disp !== 5'd0) $display("FAIL reset_value_disp got %0d want 0", value_disp); else n_pass++;
    n_chk++; if (frame_start !== 1'b0) $display("FAIL reset_frame_start got %b want 0", frame_start); else n_pass++;
    n_chk++; if (pixel_tick !== 1'b0) $display("FAIL reset_pixel_tick got %b want 0", pixel_tick); else n_pass++;
    rst = 1'b0; value_wr = 1'b0;
    cnt = 0;
    while (pixel_tick !== 1'b1 && cnt < 10) begin @(negedge clk); cnt++; end
    n_chk++; if (cnt != 3) $display("FAIL first_tick got %0d clks want 3", cnt); else n_pass++;
    while (frame_start !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
    n_chk++; if (cnt != 640) $display("FAIL first_frame_start got %0d clks want 640", cnt); else n_pass++;
    n_chk++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0)
      $display("FAIL frame_start_pos got (%0d,%0d) want (0,0)", pixel_x, pixel_y); else n_pass++;
    n_chk++; if (value_disp !== 5'd0) $display("FAIL wr_in_reset got %0d want 0", value_disp); else n_pass++;
  endtask

  task automatic test_line_timing();
    int fall_x = -1, rise_x = -1, run = 0, first_run = -1, low_total = 0, wraps = 0, bad_wrap = 0;
    int px, py;
    logic prev_hs;
    prev_hs = HSync; px = int'(pixel_x); py = int'(pixel_y);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (!HSync) begin low_total++; run++; end
      if (prev_hs && !HSync && fall_x < 0) fall_x = int'(pixel_x);
      if (!prev_hs && HSync && rise_x < 0) begin rise_x = int'(pixel_x); first_run = run; end
      if (px == 15 && int'(pixel_x) == 0) begin
        wraps++;
        if (int'(pixel_y) != py + 1) bad_wrap++;
      end
      prev_hs = HSync; px = int'(pixel_x); py = int'(pixel_y);
    end
    n_chk++; if (fall_x != 10) $display("FAIL hsync_fall_x got %0d want 10", fall_x); else n_pass++;
    n_chk++; if (rise_x != 13) $display("FAIL hsync_rise_x got %0d want 13", rise_x); else n_pass++;
    n_chk++; if (first_run != 12) $display("FAIL hsync_width got %0d want 12", first_run); else n_pass++;
    n_chk++; if (low_total != 24) $display("FAIL hsync_low_2lines got %0d want 24", low_total); else n_pass++;
    n_chk++; if (wraps != 2) $display("FAIL x_wraps got %0d want 2", wraps); else n_pass++;
    n_chk++; if (bad_wrap != 0) $display("FAIL y_increment_on_wrap got %0d bad want 0", bad_wrap); else n_pass++;
  endtask

  task automatic test_frame_timing();
    int vs_low = 0, vs_bad = 0, hs_low = 0, vid_bad = 0, vid_cnt = 0, fs_cnt = 0;
    logic vis;
    for (int i = 0; i < 640; i++) begin
      @(negedge clk);
      if (!VSync) vs_low++;
      if (!VSync != (pixel_y == 10'd6 || pixel_y == 10'd7)) vs_bad++;
      if (!HSync) hs_low++;
      vis = (pixel_x < 10'd8) && (pixel_y < 10'd5);
      if (video_on !== vis) vid_bad++;
      if (video_on) vid_cnt++;
      if (frame_start) fs_cnt++;
    end
    n_chk++; if (vs_low != 128) $display("FAIL vsync_low got %0d want 128", vs_low); else n_pass++;
    n_chk++; if (vs_bad != 0) $display("FAIL vsync_window got %0d bad want 0", vs_bad); else n_pass++;
    n_chk++; if (hs_low != 120) $display("FAIL hsync_low_frame got %0d want 120", hs_low); else n_pass++;
    n_chk++; if (vid_bad != 0) $display("FAIL video_on_area got %0d bad want 0", vid_bad); else n_pass++;
    n_chk++; if (vid_cnt != 160) $display("FAIL video_on_count got %0d want 160", vid_cnt); else n_pass++;
    n_chk++; if (fs_cnt != 1) $display("FAIL frame_start_count got %0d want 1", fs_cnt); else n_pass++;
  endtask

  task automatic test_shadow_update();
    bit ok1, ok2;
    int bad = 0, cnt = 0;
    wait_at(-1, 3, 1'b0, 700, ok1);
    value = 5'd6; value_wr = 1'b1; @(negedge clk); value_wr = 1'b0;
    wait_at(-1, 4, 1'b0, 700, ok2);
    value = 5'd7; value_wr = 1'b1; @(negedge clk); value_wr = 1'b0;
    n_chk++; if (!(ok1 && ok2)) $display("FAIL shadow_wait got ok=%b%b want 11", ok1, ok2); else n_pass++;
    while (frame_start !== 1'b1 && cnt < 700) begin
      if (value_disp !== 5'd0) bad++;
      @(negedge clk); cnt++;
    end
    n_chk++; if (bad != 0) $display("FAIL shadow_mid_frame got %0d early updates want 0", bad); else n_pass++;
    n_chk++; if (value_disp !== 5'd7) $display("FAIL shadow_last_wins got %0d want 7", value_disp); else n_pass++;
    @(negedge clk);
    cnt = 0;
    while (frame_start !== 1'b1 && cnt < 700) begin @(negedge clk); cnt++; end
    n_chk++; if (frame_start !== 1'b1 || value_disp !== 5'd7)
      $display("FAIL shadow_hold got fs=%b disp=%0d want fs=1 disp=7", frame_start, value_disp); else n_pass++;
  endtask

  task automatic test_boundary_write();
    bit ok;
    int bad = 0, cnt = 0;
    wait_at(15, 9, 1'b1, 700, ok);
    n_chk++; if (!ok) $display("FAIL boundary_wait got timeout want wrap cycle"); else n_pass++;
    value = 5'd6; value_wr = 1'b1; @(negedge clk); value_wr = 1'b0;
    n_chk++; if (frame_start !== 1'b1) $display("FAIL boundary_fs got %b want 1", frame_start); else n_pass++;
    n_chk++; if (value_disp !== 5'd7) $display("FAIL boundary_same_frame got %0d want 7", value_disp); else n_pass++;
    @(negedge clk);
    while (frame_start !== 1'b1 && cnt < 700) begin
      if (value_disp !== 5'd7) bad++;
      @(negedge clk); cnt++;
    end
    n_chk++; if (bad != 0) $display("FAIL boundary_hold got %0d bad cycles want 0", bad); else n_pass++;
    n_chk++; if (frame_start !== 1'b1 || value_disp !== 5'd6)
      $display("FAIL boundary_next_frame got fs=%b disp=%0d want fs=1 disp=6", frame_start, value_disp); else n_pass++;
  endtask

  task automatic test_mid_frame_reset();
    bit ok1, ok2;
    int cnt = 0;
    wait_at(-1, 3, 1'b0, 700, ok1);
    value = 5'd12; value_wr = 1'b1; @(negedge clk); value_wr = 1'b0;
    wait_at(11, 6, 1'b0, 700, ok2);
    n_chk++; if (!(ok1 && ok2)) $display("FAIL midrst_wait got ok=%b%b want 11", ok1, ok2); else n_pass++;
    n_chk++; if (HSync !== 1'b0 || VSync !== 1'b0)
      $display("FAIL midrst_pre_sync got hs=%b vs=%b want 0 0", HSync, VSync); else n_pass++;
    rst = 1'b1; @(negedge clk);
    n_chk++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0)
      $display("FAIL midrst_xy got (%0d,%0d) want (0,0)", pixel_x, pixel_y); else n_pass++;
    n_chk++; if (HSync !== 1'b1 || VSync !== 1'b1)
      $display("FAIL midrst_sync got hs=%b vs=%b want 1 1", HSync, VSync); else n_pass++;
    n_chk++; if (video_on !== 1'b1) $display("FAIL midrst_video_on got %b want 1", video_on); else n_pass++;
    n_chk++; if (value_disp !== 5'd0) $display("FAIL midrst_disp got %0d want 0", value_disp); else n_pass++;
    n_chk++; if (frame_start !== 1'b0 || pixel_tick !== 1'b0)
      $display("FAIL midrst_pulses got fs=%b tick=%b want 0 0", frame_start, pixel_tick); else n_pass++;
    rst = 1'b0;
    while (frame_start !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
    n_chk++; if (cnt != 640) $display("FAIL midrst_frame got %0d clks want 640", cnt); else n_pass++;
    n_chk++; if (value_disp !== 5'd0) $display("FAIL midrst_pending_dropped got %0d want 0", value_disp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_shadow_update();
    test_boundary_write();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
